controlador_rodada: RTL and testbench
=====================================

CONTROLADOR_RODADA -- requirements
Module: controlador_rodada

Interface
REQ-001 Parameter HOLD_MS, default 500, is the number of consecutive tick_ms pulses with isInPosition high required to score a hit.
REQ-002 Parameter TIMEOUT_MS, default 5000, is the number of tick_ms pulses allowed per round before a miss.
REQ-003 Parameter NUM_RODADAS, default 10, is the number of rounds per game, legal range 1..15.
REQ-004 Port clock  in  1  system clock; every flop is rising-edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port iniciar  in  1  start request, level-sampled.
REQ-007 Port tick_ms  in  1  one-cycle enable pulse, once per millisecond.
REQ-008 Port random_led  in  3  free-running pseudo-random value, any of 0..7.
REQ-009 Port isInPosition  in  1  pendulum inside the target sector, from the sector comparator.
REQ-010 Port position_led  out  3  target sector 0..4, driven to the sector comparator.
REQ-011 Port led_onehot  out  5  one-hot target LED, bit position_led; 0 when no round is active.
REQ-012 Port pontos  out  8  hit count.
REQ-013 Port rodada  out  4  number of completed rounds.
REQ-014 Port em_jogo  out  1  high in SORTEIA, AGUARDA, SEGURA, ACERTO and ERRO.
REQ-015 Port fim_jogo  out  1  high only in FIM.
REQ-016 Ports acerto and erro  out  1 each  one-cycle pulses marking a round result.

Function
REQ-017 The FSM SHALL have states IDLE, SORTEIA, AGUARDA, SEGURA, ACERTO, ERRO and FIM.
REQ-018 In IDLE or FIM, iniciar=1 SHALL clear pontos and rodada and go to SORTEIA on the next edge; iniciar SHALL be ignored in all other states.
REQ-019 SORTEIA SHALL last exactly one cycle and register the target as random_led if it is 0..4, otherwise random_led-5.
REQ-020 If the SORTEIA result equals the previous round's target, the target SHALL be (result+1) mod 5; the first round of a game is exempt.
REQ-021 SORTEIA SHALL clear the timeout and hold counters (16 bits each) and go to AGUARDA; position_led SHALL be valid from the first AGUARDA cycle.
REQ-022 The timeout counter SHALL increment on every tick_ms in AGUARDA and SEGURA, and SHALL NOT reset on leaving SEGURA.
REQ-023 AGUARDA with isInPosition=1 SHALL go to SEGURA with the hold counter cleared.
REQ-024 The hold counter SHALL increment on each tick_ms in SEGURA while isInPosition=1.
REQ-025 SEGURA with isInPosition=0 SHALL return to AGUARDA, discarding the hold count.
REQ-026 SEGURA SHALL go to ACERTO when a tick_ms brings the hold counter to HOLD_MS.
REQ-027 When the timeout counter reaches TIMEOUT_MS on a tick_ms in AGUARDA or SEGURA, the FSM SHALL go to ERRO.
REQ-028 If hold completion and timeout occur on the same tick_ms, ACERTO SHALL win.
REQ-029 ACERTO SHALL last one cycle, pulse acerto, and increment pontos, saturating at 255.
REQ-030 ERRO SHALL last one cycle and pulse erro; pontos is unchanged.
REQ-031 ACERTO and ERRO SHALL increment rodada, then go to FIM if the new value equals NUM_RODADAS, otherwise to SORTEIA.
REQ-032 FIM SHALL hold pontos, rodada and fim_jogo stable until iniciar=1.
REQ-033 All outputs SHALL be registered; led_onehot SHALL be 0 in IDLE and FIM.

Reset
REQ-034 reset_n=0 SHALL, at any time, asynchronously force IDLE and clear position_led, led_onehot, pontos, rodada, em_jogo, fim_jogo, acerto, erro, both counters and the stored previous target.
REQ-035 After reset_n deasserts, the block SHALL wait in IDLE for iniciar; a round in progress at reset is abandoned and not scored.

Verification (HOLD_MS=3, TIMEOUT_MS=10, NUM_RODADAS=2)
REQ-036 Start, random_led=6, isInPosition=1 for 3 ticks -> position_led=1, led_onehot=00010, one acerto pulse, pontos=1, rodada=1.
REQ-037 Round 2 with random_led=1 -> target becomes 2 (repeat avoided); isInPosition stays 0 for 10 ticks -> erro pulse, rodada=2, FIM, fim_jogo=1, pontos=1.
REQ-038 isInPosition high for 2 ticks, low for 1, high for 3 -> exactly one acerto, and only after the second run of 3 ticks.
REQ-039 Hold reaches 3 on the same tick the timeout reaches 10 -> acerto=1 and erro stays 0.
REQ-040 reset_n pulsed low mid-SEGURA with pontos=1 -> outputs clear without waiting for a clock edge; iniciar pulsed during AGUARDA has no effect.
REQ-041 iniciar=1 in FIM -> pontos=0, rodada=0, em_jogo=1 within one cycle.

Source files
------------

// File: rtl/controlador_rodada.sv
// Round controller for the pendulum target game: draws a target sector,
// times the hold inside it, scores hits and misses over a fixed number of rounds.
module controlador_rodada #(
  parameter int HOLD_MS     = 500,
  parameter int TIMEOUT_MS  = 5000,
  parameter int NUM_RODADAS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       tick_ms,
  input  logic [2:0] random_led,
  input  logic       isInPosition,
  output logic [2:0] position_led,
  output logic [4:0] led_onehot,
  output logic [7:0] pontos,
  output logic [3:0] rodada,
  output logic       em_jogo,
  output logic       fim_jogo,
  output logic       acerto,
  output logic       erro
);

  localparam logic [15:0] LP_HOLD = 16'(HOLD_MS);
  localparam logic [15:0] LP_TO   = 16'(TIMEOUT_MS);
  localparam logic [3:0]  LP_NR   = 4'(NUM_RODADAS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SORTEIA,
    S_AGUARDA,
    S_SEGURA,
    S_ACERTO,
    S_ERRO,
    S_FIM
  } state_t;

  state_t      r_state;
  logic [15:0] r_to;
  logic [15:0] r_hold;
  logic [2:0]  r_prev;
  logic        r_first;

  logic [2:0]  w_base;
  logic [2:0]  w_tgt;
  logic [15:0] w_to_inc;
  logic [15:0] w_hold_inc;
  logic        w_to_hit;
  logic        w_hold_done;
  logic        w_last;
  logic [7:0]  w_pontos_inc;
  logic [3:0]  w_rod_inc;

  assign w_base = (random_led > 3'd4) ? random_led - 3'd5 : random_led;

  // Never repeat the previous target, except on the first round of a game
  assign w_tgt = (!r_first && w_base == r_prev)
               ? ((w_base == 3'd4) ? 3'd0 : w_base + 3'd1)
               : w_base;

  assign w_to_inc     = r_to + 16'd1;
  assign w_hold_inc   = r_hold + 16'd1;
  assign w_to_hit     = tick_ms && (w_to_inc == LP_TO);
  assign w_hold_done  = tick_ms && isInPosition && (w_hold_inc == LP_HOLD);
  assign w_last       = (rodada == LP_NR);
  assign w_pontos_inc = (pontos == 8'hFF) ? pontos : pontos + 8'd1;
  assign w_rod_inc    = rodada + 4'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_to         <= '0;
      r_hold       <= '0;
      r_prev       <= '0;
      r_first      <= 1'b1;
      position_led <= '0;
      led_onehot   <= '0;
      pontos       <= '0;
      rodada       <= '0;
      em_jogo      <= 1'b0;
      fim_jogo     <= 1'b0;
      acerto       <= 1'b0;
      erro         <= 1'b0;
    end else begin
      acerto <= 1'b0;
      erro   <= 1'b0;
      unique case (r_state)
        S_IDLE, S_FIM: begin
          if (iniciar) begin
            pontos   <= '0;
            rodada   <= '0;
            em_jogo  <= 1'b1;
            fim_jogo <= 1'b0;
            r_first  <= 1'b1;
            r_state  <= S_SORTEIA;
          end
        end
        S_SORTEIA: begin
          position_led <= w_tgt;
          led_onehot   <= 5'b1 << w_tgt;
          r_prev       <= w_tgt;
          r_first      <= 1'b0;
          r_to         <= '0;
          r_hold       <= '0;
          r_state      <= S_AGUARDA;
        end
        S_AGUARDA: begin
          if (tick_ms) r_to <= w_to_inc;
          if (w_to_hit) begin
            erro    <= 1'b1;
            rodada  <= w_rod_inc;
            r_state <= S_ERRO;
          end else if (isInPosition) begin
            r_hold  <= '0;
            r_state <= S_SEGURA;
          end
        end
        S_SEGURA: begin
          if (tick_ms) r_to <= w_to_inc;
          // A hold completing on the timeout tick still counts as a hit
          if (w_hold_done) begin
            acerto  <= 1'b1;
            pontos  <= w_pontos_inc;
            rodada  <= w_rod_inc;
            r_state <= S_ACERTO;
          end else if (w_to_hit) begin
            erro    <= 1'b1;
            rodada  <= w_rod_inc;
            r_state <= S_ERRO;
          end else if (!isInPosition) begin
            r_hold  <= '0;
            r_state <= S_AGUARDA;
          end else if (tick_ms) begin
            r_hold <= w_hold_inc;
          end
        end
        S_ACERTO, S_ERRO: begin
          led_onehot <= '0;
          if (w_last) begin
            em_jogo  <= 1'b0;
            fim_jogo <= 1'b1;
            r_state  <= S_FIM;
          end else begin
            r_state <= S_SORTEIA;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_rodada.sv
// Bench for controlador_rodada: directed scenarios plus random games
// checked against a tick-level model of the round rules.
module tb_controlador_rodada;

  localparam int HOLD = 3;
  localparam int TO   = 10;
  localparam int NR   = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar;
  logic       tick_ms;
  logic [2:0] random_led;
  logic       isInPosition;
  logic [2:0] position_led;
  logic [4:0] led_onehot;
  logic [7:0] pontos;
  logic [3:0] rodada;
  logic       em_jogo;
  logic       fim_jogo;
  logic       acerto;
  logic       erro;

  controlador_rodada #(
    .HOLD_MS    (HOLD),
    .TIMEOUT_MS (TO),
    .NUM_RODADAS(NR)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .iniciar     (iniciar),
    .tick_ms     (tick_ms),
    .random_led  (random_led),
    .isInPosition(isInPosition),
    .position_led(position_led),
    .led_onehot  (led_onehot),
    .pontos      (pontos),
    .rodada      (rodada),
    .em_jogo     (em_jogo),
    .fim_jogo    (fim_jogo),
    .acerto      (acerto),
    .erro        (erro)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int m_pontos;
  int m_rodada;
  int m_prev;
  int m_tgt;
  int m_to;
  int m_hold;
  bit m_first;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // FSM is in SORTEIA at entry; random_led already holds this round's draw
  task automatic begin_round();
    m_tgt = int'(random_led) % 5;
    if (!m_first && m_tgt == m_prev) m_tgt = (m_tgt + 1) % 5;
    m_prev  = m_tgt;
    m_first = 0;
    m_to    = 0;
    m_hold  = 0;
    cyc();
    chk("pos", position_led, m_tgt);
    chk("onehot", led_onehot, 32'(1) << m_tgt);
    chk("em_round", em_jogo, 1);
  endtask

  task automatic start_game(input int r);
    random_led = 3'(r);
    iniciar    = 1'b1;
    cyc();
    iniciar    = 1'b0;
    m_pontos   = 0;
    m_rodada   = 0;
    m_first    = 1;
    chk("start_pontos", pontos, 0);
    chk("start_rodada", rodada, 0);
    chk("start_em", em_jogo, 1);
    chk("start_fim", fim_jogo, 0);
    begin_round();
  endtask

  task automatic do_tick(input bit inpos, output int res);
    isInPosition = inpos;
    cyc();
    cyc();
    tick_ms = 1'b1;
    cyc();
    tick_ms = 1'b0;
    m_to++;
    m_hold = inpos ? m_hold + 1 : 0;
    res = (m_hold == HOLD) ? 1 : (m_to == TO) ? 2 : 0;
    chk("acerto", acerto, res == 1);
    chk("erro", erro, res == 2);
    if (res != 0) begin
      if (res == 1 && m_pontos < 255) m_pontos++;
      m_rodada++;
      chk("res_pontos", pontos, m_pontos);
      chk("res_rodada", rodada, m_rodada);
      chk("res_em", em_jogo, 1);
    end
  endtask

  task automatic play_round(input bit rnd, input logic [15:0] pat);
    int res;
    int k;
    bit b;
    res = 0;
    k   = 0;
    while (res == 0) begin
      b = rnd ? ($urandom_range(0, 3) != 0) : pat[k[3:0]];
      do_tick(b, res);
      k++;
    end
  endtask

  task automatic finish_round(input int r_next);
    random_led   = 3'(r_next);
    isInPosition = 1'b0;
    cyc();
    chk("pulse_a_off", acerto, 0);
    chk("pulse_e_off", erro, 0);
    if (m_rodada == NR) begin
      chk("fim_fim", fim_jogo, 1);
      chk("fim_em", em_jogo, 0);
      chk("fim_led", led_onehot, 0);
      chk("fim_pontos", pontos, m_pontos);
      chk("fim_rodada", rodada, m_rodada);
    end else begin
      begin_round();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    iniciar      = 1'b0;
    tick_ms      = 1'b0;
    random_led   = 3'd0;
    isInPosition = 1'b0;
    m_prev       = 0;
    repeat (3) cyc();
    chk("rst_pos", position_led, 0);
    chk("rst_led", led_onehot, 0);
    chk("rst_pontos", pontos, 0);
    chk("rst_rodada", rodada, 0);
    chk("rst_em", em_jogo, 0);
    chk("rst_fim", fim_jogo, 0);
    chk("rst_a", acerto, 0);
    chk("rst_e", erro, 0);
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("idle_em", em_jogo, 0);

    // Game 1: hit on target 1, then forced 1->2 with a timeout miss
    start_game(6);
    chk("g1_pos", position_led, 1);
    chk("g1_led", led_onehot, 5'b00010);
    play_round(0, 16'h0007);
    finish_round(1);
    chk("g1r2_pos", position_led, 2);
    play_round(0, 16'h0000);
    finish_round(0);
    repeat (4) cyc();
    chk("fim_hold", fim_jogo, 1);
    chk("fim_hold_p", pontos, 1);
    chk("fim_hold_r", rodada, 2);

    // Game 2: broken hold then full hold; hold and timeout on same tick
    start_game($urandom_range(0, 7));
    play_round(0, 16'b11_1011);
    finish_round($urandom_range(0, 7));
    play_round(0, 16'b0000_0011_1000_0000);
    finish_round(0);

    // Game 3: iniciar ignored mid-round, then async reset in SEGURA
    start_game($urandom_range(0, 7));
    play_round(0, 16'h0007);
    finish_round($urandom_range(0, 7));
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    chk("ign_pontos", pontos, 1);
    chk("ign_rodada", rodada, 1);
    chk("ign_pos", position_led, m_tgt);
    chk("ign_em", em_jogo, 1);
    isInPosition = 1'b1;
    cyc();
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pontos", pontos, 0);
    chk("arst_rodada", rodada, 0);
    chk("arst_em", em_jogo, 0);
    chk("arst_led", led_onehot, 0);
    chk("arst_pos", position_led, 0);
    cyc();
    isInPosition = 1'b0;
    reset_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_em", em_jogo, 0);
    chk("post_rst_p", pontos, 0);

    // Random games
    for (int g = 0; g < 8; g++) begin
      start_game($urandom_range(0, 7));
      while (m_rodada < NR) begin
        play_round(1, 16'h0000);
        finish_round($urandom_range(0, 7));
      end
      repeat ($urandom_range(1, 4)) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
